// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, credit-limited imem requests, prefetch FIFO to decode, redirect flush.
module instr_fetch #(
  parameter int WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_RESET, S_RUN, S_FLUSH} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] count_q, count_d, outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2*WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic req_fire, rsp_fire, push, pop;
  always_comb begin
    imem_req_valid = state_q != S_RESET && !redirect_valid && int'(count_q) + int'(outstanding_q) < FIFO_DEPTH;
    imem_req_addr = fetch_pc_q;
    instr_valid = count_q != '0 && !redirect_valid;
    instr_data = instr_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    instr_pc = instr_valid ? mem_q[rd_ptr_q][2*WIDTH-1:WIDTH] : '0;
    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid && outstanding_q != '0;
    push = rsp_fire && !redirect_valid && drop_cnt_q == '0;
    pop = instr_valid && instr_ready;
    target = redirect_pc & ~WIDTH'(3);
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d = rsp_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d = count_q;
    outstanding_d = outstanding_q - CW'(rsp_fire);
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // Every request still in flight belongs to the abandoned stream.
      fetch_pc_d = target;
      rsp_pc_d = target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d = '0;
      drop_cnt_d = outstanding_d;
      state_d = drop_cnt_d != '0 ? S_FLUSH : S_RUN;
    end else begin
      fetch_pc_d = req_fire ? fetch_pc_q + WIDTH'(4) : fetch_pc_q;
      rsp_pc_d = push ? rsp_pc_q + WIDTH'(4) : rsp_pc_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d = count_q + CW'(push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
      drop_cnt_d = drop_cnt_q - CW'(rsp_fire && drop_cnt_q != '0);
      state_d = state_q == S_RESET ? S_RUN : state_q == S_FLUSH && drop_cnt_d == '0 ? S_RUN : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      outstanding_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {rsp_pc_q, imem_rsp_data};
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the decode/register-select stage.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instruction words with their PCs in a prefetch FIFO and presents them to decode over a valid/ready handshake. The decode stage consumes instr_data as its instruction word.
- Supports a redirect (branch/jump target) that flushes buffered and in-flight instructions.

Parameters:
WIDTH, 32, instruction and address width.
FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request this cycle
imem_req_addr  output  WIDTH  fetch address, word aligned
imem_rsp_valid  input  1  response valid; at most one per cycle, in request order
imem_rsp_data  input  WIDTH  instruction word
redirect_valid  input  1  one-cycle redirect pulse
redirect_pc  input  WIDTH  new fetch target
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts this cycle
instr_data  output  WIDTH  instruction word (feeds the decode stage instruction input)
instr_pc  output  WIDTH  PC of instr_data

Behaviour:
- Reset (rst high at an edge):
  - state=S_RESET; FIFO empty; outstanding=0; drop_cnt=0.
  - fetch_pc=RESET_PC; rsp_pc=RESET_PC.
  - All outputs 0 except imem_req_addr=RESET_PC.
  - Reset asserted mid-operation abandons everything. Responses arriving after reset for pre-reset requests are a system error and are not tracked.
- FSM:
  - S_RESET: request suppressed; next state S_RUN.
  - S_RUN: normal operation. On redirect with stale in-flight requests (drop count computed below > 0), go to S_FLUSH; otherwise stay.
  - S_FLUSH: same as S_RUN, but responses are discarded while drop_cnt>0. Go to S_RUN on the cycle drop_cnt reaches 0. A further redirect reloads drop_cnt and stays in S_FLUSH.
- Request channel:
  - imem_req_valid = (state!=S_RESET) && !redirect_valid && (fifo_count+outstanding < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps modulo 2^WIDTH); outstanding++.
  - Address is stable while valid is held; valid is withdrawn without acceptance only by redirect.
- Response channel:
  - Every imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: data discarded; drop_cnt--.
  - Otherwise: push {rsp_pc, imem_rsp_data}; rsp_pc += 4.
  - imem_rsp_valid with outstanding==0 is ignored (no state change).
  - The credit rule guarantees no push when full.
- Output:
  - instr_valid = fifo not empty && !redirect_valid.
  - instr_data/instr_pc come from the head entry and are 0 when instr_valid is low.
  - Pop on instr_valid&&instr_ready. Push and pop in the same cycle are both honoured; count unchanged.
- Latency:
  - A response at edge T makes instr_valid high from T+1.
  - With a zero-wait memory (response the cycle after acceptance), first instruction is visible 2 cycles after request accept.
  - Sustained throughput is 1 instruction/cycle.
- Redirect (redirect_valid high):
  - Priority over everything. No request issued, no pop, and any response that cycle is discarded.
  - Next edge: FIFO emptied; fetch_pc = rsp_pc = {redirect_pc[WIDTH-1:2],2'b00}.
  - drop_cnt = outstanding - imem_rsp_valid; outstanding updated the same way.
  - Redirect also clears any residual drop_cnt state before reloading.

Test Plan:
1. Reset, zero-wait memory, instr_ready=1 -> requests at 0x0,0x4,0x8,...; instr_valid from 2 cycles after first accept; instr_pc/instr_data sequence matches memory, 1 per cycle.
2. instr_ready=0 with DEPTH=4 -> exactly 4 requests accepted, imem_req_valid then low; FIFO holds PCs 0x0..0xC; releasing ready drains them in order and fetching resumes.
3. 3-cycle memory latency, 3 requests outstanding, redirect to 0x103 -> next request addr 0x100; 3 stale responses discarded; first instr_pc delivered is 0x100.
4. Redirect coincident with a response and a decode-ready head -> response discarded, no pop counted, drop_cnt = outstanding-1, FIFO empty next cycle.
5. Back-to-back redirects (0x200 then 0x300) while in S_FLUSH -> no instruction from 0x200 stream delivered, stream resumes at 0x300.
6. fetch_pc 0xFFFF_FFFC -> next request address 0x0000_0000; rst asserted mid-stream -> outputs return to reset values next edge, fetching restarts at RESET_PC.
